// File: rtl/cdb_arbiter_if.sv
// Bundles the FU result ports and the CDB broadcast of cdb_arbiter.
// master = FU/listener side, slave = arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_FU = 4,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32
);
   logic                    squash;
   logic [NUM_FU-1:0]       fu_valid;
   logic [NUM_FU*TAG_W-1:0] fu_rob_tag;
   logic [NUM_FU*XLEN-1:0]  fu_value;
   logic [NUM_FU-1:0]       fu_ready;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_rob_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [31:0]             conflict_cnt;
   logic                    err_zero_tag;

   modport master (
      output squash, fu_valid, fu_rob_tag, fu_value,
      input  fu_ready, cdb_valid, cdb_rob_tag, cdb_value, conflict_cnt, err_zero_tag
   );

   modport slave (
      input  squash, fu_valid, fu_rob_tag, fu_value,
      output fu_ready, cdb_valid, cdb_rob_tag, cdb_value, conflict_cnt, err_zero_tag
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per FU, round-robin grant of one
// buffer per cycle, winner broadcast on a registered CDB packet.
module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32
) (
   input logic          clock,
   input logic          reset,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] hold_valid;
   logic [TAG_W-1:0]  hold_tag   [NUM_FU];
   logic [XLEN-1:0]   hold_value [NUM_FU];
   logic [PTR_W-1:0]  rr_ptr;

   logic [NUM_FU-1:0] grant;
   logic              grant_any;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  rr_next;
   logic [NUM_FU-1:0] ready;
   logic [NUM_FU-1:0] accept;
   logic              multi_held;

   logic              cdb_valid_q;
   logic [TAG_W-1:0]  cdb_tag_q;
   logic [XLEN-1:0]   cdb_value_q;
   logic [31:0]       conflict_q;
   logic              err_zero_q;

   // Round-robin search starting at rr_ptr; first held buffer wins.
   always_comb begin
      int idx;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         if (!grant_any && hold_valid[PTR_W'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
      rr_next = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
   end

   // A buffer being drained this cycle can be refilled in the same cycle.
   always_comb begin
      int held_cnt;
      ready    = {NUM_FU{!bus.squash}} & (~hold_valid | grant);
      accept   = bus.fu_valid & ready;
      held_cnt = 0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (hold_valid[i]) held_cnt = held_cnt + 1;
      end
      multi_held = (held_cnt >= 2);
   end

   // Squash drops everything held but leaves rr_ptr and the statistics alone;
   // tag-0 results are swallowed and only flagged.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid  <= '0;
         rr_ptr      <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
         conflict_q  <= '0;
         err_zero_q  <= 1'b0;
      end else begin
         if (multi_held && conflict_q != '1) conflict_q <= conflict_q + 32'd1;
         if (bus.squash) begin
            hold_valid  <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
         end else begin
            if (grant_any) begin
               rr_ptr      <= rr_next;
               cdb_valid_q <= 1'b1;
               cdb_tag_q   <= hold_tag[grant_idx];
               cdb_value_q <= hold_value[grant_idx];
            end else begin
               cdb_valid_q <= 1'b0;
               cdb_tag_q   <= '0;
               cdb_value_q <= '0;
            end
            for (int i = 0; i < NUM_FU; i++) begin
               if (accept[i]) begin
                  if (bus.fu_rob_tag[i*TAG_W +: TAG_W] != '0) begin
                     hold_valid[i] <= 1'b1;
                     hold_tag[i]   <= bus.fu_rob_tag[i*TAG_W +: TAG_W];
                     hold_value[i] <= bus.fu_value[i*XLEN +: XLEN];
                  end else begin
                     hold_valid[i] <= 1'b0;
                     err_zero_q    <= 1'b1;
                  end
               end else if (grant[i]) begin
                  hold_valid[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.fu_ready     = ready;
   assign bus.cdb_valid    = cdb_valid_q;
   assign bus.cdb_rob_tag  = cdb_tag_q;
   assign bus.cdb_value    = cdb_value_q;
   assign bus.conflict_cnt = conflict_q;
   assign bus.err_zero_tag = err_zero_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: latency, round-robin order, fairness,
// squash, tag-0 handling and reset in the middle of traffic.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int TW = 5;
   localparam int XW = 32;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   cdb_arbiter_if #(.NUM_FU(N), .TAG_W(TW), .XLEN(XW)) bus ();

   cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .XLEN(XW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      bus.squash     = 1'b0;
      bus.fu_valid   = '0;
      bus.fu_rob_tag = '0;
      bus.fu_value   = '0;
   endtask

   task automatic set_fu(input int i, input logic [TW-1:0] tag, input logic [XW-1:0] val);
      bus.fu_valid[i]           = 1'b1;
      bus.fu_rob_tag[i*TW +: TW] = tag;
      bus.fu_value[i*XW +: XW]   = val;
   endtask

   // Tagged results in the directed tests carry value A000_0000 | tag.
   function automatic logic [XW-1:0] val_of(input logic [TW-1:0] tag);
      return (tag == '0) ? '0 : (32'hA000_0000 | XW'(tag));
   endfunction

   task automatic apply_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset();
      checks++;
      if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_tag !== '0 || bus.cdb_value !== '0) begin
         failures++;
         $display("[TB] FAIL reset_cdb: got v=%0b tag=%0d val=%h want 0/0/0",
                  bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value);
      end
      checks++;
      if (bus.conflict_cnt !== 32'd0 || bus.err_zero_tag !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_stats: got conflict=%0d err=%0b want 0/0",
                  bus.conflict_cnt, bus.err_zero_tag);
      end
      checks++;
      if (bus.fu_ready !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL reset_ready: got %b want 1111", bus.fu_ready);
      end
   endtask

   task automatic test_single;
      set_fu(0, 5'd5, 32'h0000_DEAD);
      tick();
      idle_inputs();
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_n1: got cdb_valid=%0b want 0", bus.cdb_valid);
      end
      tick();
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== 5'd5 || bus.cdb_value !== 32'h0000_DEAD) begin
         failures++;
         $display("[TB] FAIL single_n2: got v=%0b tag=%0d val=%h want 1/5/0000dead",
                  bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value);
      end
      tick();
      checks++;
      if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_tag !== '0 || bus.cdb_value !== '0) begin
         failures++;
         $display("[TB] FAIL single_n3: got v=%0b tag=%0d val=%h want 0/0/0",
                  bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value);
      end
   endtask

   task automatic test_all_fu;
      logic [TW-1:0] exp_tag [7] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (bus.cdb_valid !== (exp_tag[k] != '0) || bus.cdb_rob_tag !== exp_tag[k] ||
             bus.cdb_value !== val_of(exp_tag[k])) begin
            failures++;
            $display("[TB] FAIL all_fu_c%0d: got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                     k, bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, exp_tag[k], val_of(exp_tag[k]));
         end
         idle_inputs();
         if (k == 0) begin
            for (int i = 0; i < N; i++) set_fu(i, TW'(i + 1), val_of(TW'(i + 1)));
         end
         #1;
         if (k == 1) begin
            checks++;
            if (bus.fu_ready !== 4'b0001) begin
               failures++;
               $display("[TB] FAIL all_fu_ready_c1: got %b want 0001", bus.fu_ready);
            end
         end
         if (k == 2) begin
            checks++;
            if (bus.fu_ready !== 4'b0011) begin
               failures++;
               $display("[TB] FAIL all_fu_ready_c2: got %b want 0011", bus.fu_ready);
            end
         end
         tick();
      end
      checks++;
      if (bus.conflict_cnt !== 32'd3) begin
         failures++;
         $display("[TB] FAIL all_fu_conflict: got %0d want 3", bus.conflict_cnt);
      end
   endtask

   task automatic test_fairness;
      logic          fu2_v   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [TW-1:0] fu2_tag [8] = '{5'd20, 5'd21, 5'd22, 5'd22, 5'd23, 5'd0, 5'd0, 5'd0};
      logic [TW-1:0] exp_tag [8] = '{5'd0, 5'd0, 5'd20, 5'd10, 5'd21, 5'd22, 5'd23, 5'd0};
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.cdb_valid !== (exp_tag[k] != '0) || bus.cdb_rob_tag !== exp_tag[k] ||
             bus.cdb_value !== val_of(exp_tag[k])) begin
            failures++;
            $display("[TB] FAIL fair_c%0d: got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                     k, bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, exp_tag[k], val_of(exp_tag[k]));
         end
         idle_inputs();
         if (fu2_v[k]) set_fu(2, fu2_tag[k], val_of(fu2_tag[k]));
         if (k == 1) set_fu(0, 5'd10, val_of(5'd10));
         #1;
         if (k == 2) begin
            checks++;
            if (bus.fu_ready !== 4'b1011) begin
               failures++;
               $display("[TB] FAIL fair_ready_c2: got %b want 1011", bus.fu_ready);
            end
         end
         tick();
      end
      checks++;
      if (bus.conflict_cnt !== 32'd1) begin
         failures++;
         $display("[TB] FAIL fair_conflict: got %0d want 1", bus.conflict_cnt);
      end
   endtask

   task automatic test_squash;
      logic [TW-1:0] exp_tag [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd11, 5'd12, 5'd0};
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (bus.cdb_valid !== (exp_tag[k] != '0) || bus.cdb_rob_tag !== exp_tag[k] ||
             bus.cdb_value !== val_of(exp_tag[k])) begin
            failures++;
            $display("[TB] FAIL squash_c%0d: got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                     k, bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, exp_tag[k], val_of(exp_tag[k]));
         end
         idle_inputs();
         case (k)
            0: begin
               set_fu(0, 5'd6, val_of(5'd6));
               set_fu(1, 5'd7, val_of(5'd7));
               set_fu(3, 5'd8, val_of(5'd8));
            end
            1: begin
               bus.squash = 1'b1;
               set_fu(2, 5'd9, val_of(5'd9));
            end
            2: begin
               set_fu(0, 5'd11, val_of(5'd11));
               set_fu(1, 5'd12, val_of(5'd12));
            end
            default: ;
         endcase
         #1;
         if (k == 1) begin
            checks++;
            if (bus.fu_ready !== 4'b0000) begin
               failures++;
               $display("[TB] FAIL squash_ready_during: got %b want 0000", bus.fu_ready);
            end
         end
         if (k == 2) begin
            checks++;
            if (bus.fu_ready !== 4'b1111 || bus.conflict_cnt !== 32'd1) begin
               failures++;
               $display("[TB] FAIL squash_after: got ready=%b conflict=%0d want 1111/1",
                        bus.fu_ready, bus.conflict_cnt);
            end
         end
         tick();
      end
      checks++;
      if (bus.conflict_cnt !== 32'd2) begin
         failures++;
         $display("[TB] FAIL squash_conflict: got %0d want 2", bus.conflict_cnt);
      end
   endtask

   task automatic test_zero_tag;
      apply_reset();
      set_fu(1, 5'd0, 32'd7);
      tick();
      idle_inputs();
      checks++;
      if (bus.err_zero_tag !== 1'b1 || bus.fu_ready !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL zero_tag_flag: got err=%0b ready=%b want 1/1111",
                  bus.err_zero_tag, bus.fu_ready);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (bus.cdb_valid !== 1'b0 || bus.err_zero_tag !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_tag_c%0d: got v=%0b err=%0b want 0/1",
                     k, bus.cdb_valid, bus.err_zero_tag);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [TW-1:0] exp_tag [10] = '{5'd0, 5'd0, 5'd15, 5'd0, 5'd14, 5'd17,
                                      5'd0, 5'd0, 5'd18, 5'd19};
      apply_reset();
      checks++;
      if (bus.err_zero_tag !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_err_clear: got %0b want 0", bus.err_zero_tag);
      end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (bus.cdb_valid !== (exp_tag[k] != '0) || bus.cdb_rob_tag !== exp_tag[k] ||
             bus.cdb_value !== val_of(exp_tag[k])) begin
            failures++;
            $display("[TB] FAIL rmid_c%0d: got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                     k, bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, exp_tag[k], val_of(exp_tag[k]));
         end
         if (k == 5) begin
            checks++;
            if (bus.conflict_cnt !== 32'd2) begin
               failures++;
               $display("[TB] FAIL rmid_conflict_pre: got %0d want 2", bus.conflict_cnt);
            end
         end
         if (k == 6) begin
            checks++;
            if (bus.conflict_cnt !== 32'd0 || bus.fu_ready !== 4'b1111) begin
               failures++;
               $display("[TB] FAIL rmid_post_reset: got conflict=%0d ready=%b want 0/1111",
                        bus.conflict_cnt, bus.fu_ready);
            end
         end
         idle_inputs();
         reset = 1'b0;
         case (k)
            0: set_fu(2, 5'd15, val_of(5'd15));
            2: begin
               set_fu(0, 5'd17, val_of(5'd17));
               set_fu(1, 5'd13, val_of(5'd13));
               set_fu(2, 5'd16, val_of(5'd16));
               set_fu(3, 5'd14, val_of(5'd14));
            end
            5: reset = 1'b1;
            6: begin
               set_fu(0, 5'd18, val_of(5'd18));
               set_fu(1, 5'd19, val_of(5'd19));
            end
            default: ;
         endcase
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_all_fu();
      test_fairness();
      test_squash();
      test_zero_tag();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
